// File: rtl/bram_dump_pkg.sv
// Shared definitions for the BRAM-to-UART dump sequencer: state encoding,
// completion status codes and front-panel LED patterns.
package bram_dump_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_WAIT_RD = 3'd2,
    S_LOAD    = 3'd3,
    S_REQ     = 3'd4,
    S_ACK     = 3'd5,
    S_TXW     = 3'd6,
    S_NEXT    = 3'd7
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ABORT   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  localparam logic [7:0] LED_IDLE = 8'b1100_0000;
  localparam logic [7:0] LED_RD   = 8'b0011_0000;
  localparam logic [7:0] LED_TX   = 8'b0000_1100;
  localparam logic [7:0] LED_NEXT = 8'b0000_0011;
  localparam logic [7:0] LED_ERR  = 8'b0000_0001;

  function automatic logic [7:0] led_of(input state_t s, input logic [1:0] st);
    logic [7:0] p;
    case (s)
      S_IDLE:                    p = LED_IDLE;
      S_ADDR, S_WAIT_RD, S_LOAD: p = LED_RD;
      S_REQ, S_ACK, S_TXW:       p = LED_TX;
      default:                   p = LED_NEXT;
    endcase
    return (st != ST_OK) ? (p | LED_ERR) : p;
  endfunction

endpackage

// File: rtl/bram_dump_ctrl.sv
// Walks a block of BRAM and streams each byte to the UART transmitter with a
// req/busy handshake; bounded length, wrap-around addressing, abort and ack timeout.
module bram_dump_ctrl
  import bram_dump_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int RD_LAT = 1,
  parameter int ACK_TO = 16
) (
  input  logic              CLK_50M,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [7:0]        bram_dout,
  output logic [7:0]        uart_din,
  output logic              uart_req,
  input  logic              uart_busy,
  output logic              active,
  output logic              done,
  output logic [1:0]        status,
  output logic [ADDR_W:0]   sent_cnt,
  output logic [7:0]        state_led
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam int TO_W = (ACK_TO > 2) ? $clog2(ACK_TO) : 1;

  state_t            state, state_nx;
  logic [ADDR_W:0]   len_eff, len_in;
  logic [TO_W-1:0]   to_cnt;
  logic [1:0]        lat_cnt;
  logic              abort_pend;
  logic              done_nx, ld_start, inc_sent, adv_addr;
  logic [1:0]        status_nx;

  assign len_in   = (length > DEPTH) ? DEPTH : length;
  assign bram_en  = (state == S_ADDR) || (state == S_WAIT_RD) || (state == S_LOAD);
  // An abort arriving in the REQ cycle suppresses the request outright.
  assign uart_req = (state == S_REQ) && !abort;
  assign active   = (state != S_IDLE);

  always_comb begin
    state_nx  = state;
    done_nx   = 1'b0;
    status_nx = status;
    ld_start  = 1'b0;
    inc_sent  = 1'b0;
    adv_addr  = 1'b0;
    case (state)
      S_IDLE:
        if (start) begin
          ld_start  = 1'b1;
          status_nx = ST_OK;
          if (len_in == '0) done_nx  = 1'b1;
          else              state_nx = S_ADDR;
        end
      S_ADDR, S_WAIT_RD, S_LOAD, S_REQ:
        if (abort) begin
          state_nx  = S_IDLE;
          done_nx   = 1'b1;
          status_nx = ST_ABORT;
        end else begin
          case (state)
            S_ADDR:    state_nx = (RD_LAT == 1) ? S_LOAD : S_WAIT_RD;
            S_WAIT_RD: if (lat_cnt == 2'(RD_LAT - 2)) state_nx = S_LOAD;
            S_LOAD:    state_nx = S_REQ;
            default:   state_nx = S_ACK;
          endcase
        end
      S_ACK:
        if (uart_busy) state_nx = S_TXW;
        else if (to_cnt == TO_W'(ACK_TO - 2)) begin
          state_nx  = S_IDLE;
          done_nx   = 1'b1;
          status_nx = ST_TIMEOUT;
        end
      S_TXW:
        if (!uart_busy) begin
          inc_sent = 1'b1;
          state_nx = S_NEXT;
        end
      S_NEXT:
        if (sent_cnt == len_eff) begin
          state_nx  = S_IDLE;
          done_nx   = 1'b1;
          status_nx = ST_OK;
        end else if (abort || abort_pend) begin
          state_nx  = S_IDLE;
          done_nx   = 1'b1;
          status_nx = ST_ABORT;
        end else begin
          adv_addr = 1'b1;
          state_nx = S_ADDR;
        end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      len_eff    <= '0;
      bram_addr  <= '0;
      uart_din   <= '0;
      done       <= 1'b0;
      status     <= ST_OK;
      sent_cnt   <= '0;
      state_led  <= '0;
      to_cnt     <= '0;
      lat_cnt    <= '0;
      abort_pend <= 1'b0;
    end else begin
      state     <= state_nx;
      done      <= done_nx;
      status    <= status_nx;
      state_led <= led_of(state_nx, status_nx);
      if (ld_start) begin
        bram_addr  <= base_addr;
        len_eff    <= len_in;
        sent_cnt   <= '0;
        abort_pend <= 1'b0;
      end
      if (adv_addr) bram_addr <= bram_addr + ADDR_W'(1);
      if (inc_sent) sent_cnt  <= sent_cnt + (ADDR_W+1)'(1);
      if (state == S_LOAD) uart_din <= bram_dout;
      lat_cnt <= (state == S_WAIT_RD) ? lat_cnt + 2'd1 : 2'd0;
      to_cnt  <= (state == S_ACK) ? to_cnt + TO_W'(1) : '0;
      // An abort seen mid-byte is remembered and honoured at the byte boundary.
      if (abort && (state == S_ACK || state == S_TXW)) abort_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bram_dump_ctrl.sv
// Randomized bench for bram_dump_ctrl: BRAM and UART models plus a
// per-run reference of expected bytes, addresses and completion status.
module tb_bram_dump_ctrl;
  localparam int AW = 11;
  localparam int DEPTH = 2048;

  logic          CLK_50M = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          bram_en, uart_req, active, done;
  logic [AW-1:0] bram_addr;
  logic [7:0]    bram_dout = 8'h00, uart_din, state_led;
  logic          uart_busy = 1'b0;
  logic [1:0]    status;
  logic [AW:0]   sent_cnt;

  bram_dump_ctrl #(.ADDR_W(AW), .RD_LAT(1), .ACK_TO(16)) dut (
    .CLK_50M(CLK_50M), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length), .bram_en(bram_en),
    .bram_addr(bram_addr), .bram_dout(bram_dout), .uart_din(uart_din),
    .uart_req(uart_req), .uart_busy(uart_busy), .active(active), .done(done),
    .status(status), .sent_cnt(sent_cnt), .state_led(state_led)
  );

  always #10 CLK_50M = ~CLK_50M;

  int cyc = 0;
  always @(posedge CLK_50M) cyc <= cyc + 1;

  logic [7:0] mem [DEPTH];
  always @(posedge CLK_50M) if (bram_en) bram_dout <= mem[bram_addr];

  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // UART model: records each request, then raises busy for a random while.
  bit            uart_dead = 1'b0;
  int            abort_byte = 0;
  int            first_req_cyc = -1;
  logic [AW-1:0] rec_addr[$];
  logic [7:0]    rec_data[$];

  initial forever begin
    @(posedge CLK_50M); #1;
    if (uart_req) begin
      rec_addr.push_back(bram_addr);
      rec_data.push_back(uart_din);
      if (rec_addr.size() == 1) first_req_cyc = cyc;
      if (!uart_dead) begin
        automatic int d1 = $urandom_range(2, 0);
        automatic int d2 = $urandom_range(2, 0);
        repeat (d1) begin @(posedge CLK_50M); #1; end
        uart_busy = 1'b1;
        @(posedge CLK_50M); #1;
        if (rec_addr.size() == abort_byte) abort = 1'b1;
        @(posedge CLK_50M); #1;
        abort = 1'b0;
        repeat (d2) begin @(posedge CLK_50M); #1; end
        uart_busy = 1'b0;
      end
    end
  end

  task automatic run(input int base, input int len, input int ab, input bit dead, input bit pre_ab);
    int len_eff, n_exp, n_req, st_exp, t0, waited, done_cyc;
    bit got_done;
    len_eff = (len > DEPTH) ? DEPTH : len;
    if (pre_ab && len_eff > 0)      begin n_exp = 0;       st_exp = 1; end
    else if (dead && len_eff > 0)   begin n_exp = 0;       st_exp = 2; end
    else if (ab > 0 && ab < len_eff) begin n_exp = ab;     st_exp = 1; end
    else                            begin n_exp = len_eff; st_exp = 0; end
    n_req = (dead && !pre_ab && len_eff > 0) ? 1 : n_exp;
    rec_addr.delete(); rec_data.delete();
    abort_byte = ab; uart_dead = dead; first_req_cyc = -1;

    @(posedge CLK_50M); #1;
    base_addr = AW'(base); length = (AW+1)'(len); start = 1'b1; abort = pre_ab;
    @(posedge CLK_50M); #1;
    start = 1'b0; t0 = cyc;
    got_done = done; waited = 0;
    while (!got_done && waited < 40 * len_eff + 100) begin
      @(posedge CLK_50M); #1;
      waited++;
      got_done = done;
    end
    done_cyc = cyc;
    abort = 1'b0;

    chk("done_seen", 32'(got_done), 1);
    chk("status", 32'(status), st_exp);
    chk("sent_cnt", 32'(sent_cnt), n_exp);
    chk("n_req", rec_addr.size(), n_req);
    chk("state_led", 32'(state_led), (st_exp != 0) ? 32'hC1 : 32'hC0);
    for (int i = 0; i < rec_addr.size() && i < n_req; i++) begin
      automatic int a = (base + i) % DEPTH;
      chk("byte_addr", 32'(rec_addr[i]), a);
      chk("byte_data", 32'(rec_data[i]), 32'(mem[a]));
    end
    if (n_req > 0) chk("first_req_lat", first_req_cyc - t0, 2);
    if (len_eff == 0) chk("zero_len_done_lat", done_cyc - t0, 0);
    if (dead && len_eff > 0 && !pre_ab) chk("ack_timeout_lat", done_cyc - first_req_cyc, 16);
    if (len > DEPTH && rec_addr.size() > 0)
      chk("wrap_last_addr", 32'(rec_addr[rec_addr.size()-1]), (base + DEPTH - 1) % DEPTH);
    @(posedge CLK_50M); #1;
    chk("done_one_cycle", 32'(done), 0);
    chk("idle_after_done", 32'(active), 0);
  endtask

  initial begin
    int waited;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) mem[i] = 8'(8'h10 + i);

    repeat (3) @(posedge CLK_50M); #1;
    chk("reset_ctl", {29'd0, active, done, uart_req}, 0);
    chk("reset_data", {status, sent_cnt, state_led, bram_en, bram_addr}, 0);
    rst_n = 1'b1;

    run(0, 4, 0, 0, 0);
    run(2046, 4, 0, 0, 0);
    run(7, 0, 0, 0, 0);
    run(300, 3000, 0, 0, 0);
    run(50, 10, 2, 0, 0);
    run(9, 5, 0, 1, 0);
    run(20, 6, 0, 0, 1);
    run(100, 3, 3, 0, 0);
    for (int k = 0; k < 6; k++) begin
      automatic int l = $urandom_range(20, 1);
      run($urandom_range(DEPTH - 1, 0), l, $urandom_range(l + 1, 0), 1'b0, 1'b0);
    end

    // Reset dropped while a byte is on the wire.
    rec_addr.delete(); rec_data.delete(); abort_byte = 0; uart_dead = 1'b0;
    @(posedge CLK_50M); #1;
    base_addr = AW'(100); length = (AW+1)'(5); start = 1'b1;
    @(posedge CLK_50M); #1;
    start = 1'b0;
    waited = 0;
    while (!uart_busy && waited < 50) begin @(posedge CLK_50M); #1; waited++; end
    chk("busy_before_reset", 32'(uart_busy), 1);
    @(posedge CLK_50M); #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_ctl", {29'd0, active, done, uart_req}, 0);
    chk("async_reset_data", {status, sent_cnt, state_led, bram_en, bram_addr}, 0);
    chk("async_reset_din", 32'(uart_din), 0);
    repeat (8) @(posedge CLK_50M); #1;
    rst_n = 1'b1;
    run(5, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bram_dump_ctrl.md
Name: bram_dump_ctrl

Overview:
- Sequences a complete read-and-transmit dump of an 8-bit x 2k block RAM over the UART transmitter.
- Issues BRAM addresses and captures read data at the configured read latency. Hands each byte to the UART with a req/busy handshake and advances to the next address.
- Runs a bounded, wrap-safe transfer with abort and timeout handling, and reports completion status.
- Sits between the top-level control inputs, the BRAM port A and new_uart_tx.

Parameters:
- ADDR_W, 11, BRAM address width; depth = 2**ADDR_W.
- RD_LAT, 1, BRAM read latency in cycles from address to valid dout; legal values 1 or 2.
- ACK_TO, 16, maximum number of cycles after uart_req for uart_busy to rise.

Ports:
- CLK_50M  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  start request, sampled in IDLE only.
- abort  in  1  level; stop at the next byte boundary.
- base_addr  in  ADDR_W  first BRAM address, sampled on start.
- length  in  ADDR_W+1  byte count, sampled on start.
- bram_en  out  1  BRAM port enable.
- bram_addr  out  ADDR_W  BRAM address, registered.
- bram_dout  in  8  BRAM read data.
- uart_din  out  8  byte to transmit.
- uart_req  out  1  one-cycle transmit request.
- uart_busy  in  1  UART busy.
- active  out  1  high while not in IDLE.
- done  out  1  one-cycle completion pulse.
- status  out  2  00 ok, 01 aborted, 10 ack timeout; held until the next accepted start.
- sent_cnt  out  ADDR_W+1  bytes fully transmitted in the current or last run.
- state_led  out  8  state indicator pattern.

Behaviour:
- Reset: all outputs 0, state IDLE, internal counters 0. Reset is asynchronous and takes effect mid-transfer; no done pulse is produced by reset.
- States: IDLE, ADDR, WAIT_RD, LOAD, REQ, ACK, TXW, NEXT.
- IDLE:
  - start=1 latches base_addr and len_eff, clears sent_cnt and status, and goes to ADDR.
  - len_eff = min(length, 2**ADDR_W).
  - If len_eff == 0: go straight back to IDLE with done=1 and status 00 the next cycle. No BRAM or UART activity.
- ADDR: bram_en=1, bram_addr = current address. Go to LOAD if RD_LAT=1, else to WAIT_RD for RD_LAT-1 cycles.
- LOAD: bram_en=1; capture bram_dout into uart_din. uart_din is held stable until the next LOAD.
- REQ: uart_req=1 for exactly one cycle, then go to ACK.
- ACK:
  - Wait for uart_busy=1, then go to TXW.
  - If uart_busy has not risen by ACK_TO cycles after REQ: go to IDLE with done=1 and status 10. The failed byte is not counted.
- TXW: wait for uart_busy=0, then sent_cnt+1, then go to NEXT.
- NEXT:
  - If sent_cnt == len_eff: go to IDLE with done=1 and status 00.
  - Else if abort: go to IDLE with done=1 and status 01.
  - Else: address +1 modulo 2**ADDR_W (natural wrap; 2047 -> 0), then go to ADDR.
- Abort handling:
  - abort in ADDR, WAIT_RD, LOAD or REQ-pending: go to IDLE the next cycle with done=1 and status 01, and no uart_req is issued.
  - abort in ACK or TXW: the in-flight byte completes, then abort is honoured in NEXT.
  - Last byte completing at the same time as abort: status 00.
  - abort in IDLE is ignored.
  - start and abort high together in IDLE: start accepted; abort is evaluated from ADDR onward.
- start outside IDLE is ignored.
- Latency for RD_LAT=1 with start sampled at cycle t: ADDR at t+1, LOAD at t+2, uart_req at t+3. Each further byte costs 4 cycles plus the UART busy time.
- state_led patterns:
  - IDLE 8'b11000000.
  - ADDR/WAIT_RD/LOAD 8'b00110000.
  - REQ/ACK/TXW 8'b00001100.
  - NEXT 8'b00000011.
  - OR 8'b00000001 while status != 00.

Decomposition:
- Package bram_dump_pkg: state encoding (3-bit), status codes ST_OK, ST_ABORT and ST_TIMEOUT, state_led pattern constants.
- Single module. The ack-timeout counter and read-latency counter are inline; no sub-module is warranted.

Test Plan:
1. BRAM[0..3] = 0x10..0x13; base=0, length=4, start -> 4 uart_req pulses carrying 0x10, 0x11, 0x12, 0x13; done with status 00; sent_cnt=4; first uart_req 3 cycles after start.
2. base=2046, length=4 -> bram_addr sequence 2046, 2047, 0, 1; status 00.
3. length=0 -> done one cycle after start, no uart_req, sent_cnt=0. length=3000 -> exactly 2048 bytes, ending at address base-1 mod 2048.
4. length=10; abort pulsed while uart_busy=1 on byte 2 -> byte 2 completes, no further uart_req, done with status 01, sent_cnt=2.
5. uart_busy held at 0 -> 16 cycles after uart_req: done with status 10, sent_cnt=0, state_led=8'b11000001.
6. rst_n low mid-TXW -> all outputs 0 asynchronously. After release, start with base=5, length=1 -> one byte sent from address 5, status 00.
